// File: rtl/logic_pkg.sv
// Shared encodings for the sequential logic unit: op codes, FSM states and a
// helper that sizes the chunk counter.
package logic_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_ANDN = 3'b011;
  localparam logic [2:0] OP_ORN  = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;
  localparam logic [2:0] OP_NAND = 3'b110;
  localparam logic [2:0] OP_NOR  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A single chunk still needs a 1-bit counter so the select logic stays uniform.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/logic_unit_seq_if.sv
// Operand/result handshake bundle; master is the producer/consumer side,
// slave is the logic unit.
interface logic_unit_seq_if #(
  parameter int N = 32
) ();
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [2:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] result;
  logic         zero;
  logic         ones;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, zero, ones
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, zero, ones
  );
endinterface

// File: rtl/logic_slice.sv
// W-bit combinational bitwise operator; one instance is reused for every
// chunk of a wide operand. Zero latency, no flow control.
module logic_slice
  import logic_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a_s,
  input  logic [W-1:0] b_s,
  input  logic [2:0]   op,
  output logic [W-1:0] y_s
);

  always_comb begin
    y_s = '0;
    case (op)
      OP_AND:  y_s = a_s & b_s;
      OP_OR:   y_s = a_s | b_s;
      OP_XOR:  y_s = a_s ^ b_s;
      OP_ANDN: y_s = a_s & ~b_s;
      OP_ORN:  y_s = a_s | ~b_s;
      OP_XNOR: y_s = ~(a_s ^ b_s);
      OP_NAND: y_s = ~(a_s & b_s);
      OP_NOR:  y_s = ~(a_s | b_s);
      default: y_s = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_seq.sv
// N-bit bitwise logic engine walking W bits per cycle; result valid N/W cycles
// after accept, held in DONE (with flags) until out_ready, no accept outside IDLE.
module logic_unit_seq
  import logic_pkg::*;
#(
  parameter int N = 32,
  parameter int W = 8
) (
  input logic            clk,
  input logic            rst_n,
  logic_unit_seq_if.slave io
);

  localparam int CHUNKS = N / W;
  localparam int CW     = cnt_width(CHUNKS);
  localparam logic [CW-1:0] LAST = CW'(CHUNKS - 1);

  state_t        state;
  logic [CW-1:0] k;
  logic [N-1:0]  a_q;
  logic [N-1:0]  b_q;
  logic [2:0]    op_q;
  logic [N-1:0]  result_q;
  logic          zero_q;
  logic          ones_q;
  logic          in_ready_q;
  logic          out_valid_q;

  logic [W-1:0]  a_s;
  logic [W-1:0]  b_s;
  logic [W-1:0]  y_s;
  logic [N-1:0]  res_next;

  // Constant-index mux keeps the chunk select clean for every N/W ratio.
  always_comb begin
    a_s = '0;
    b_s = '0;
    for (int i = 0; i < CHUNKS; i++) begin
      if (k == CW'(i)) begin
        a_s = a_q[i*W +: W];
        b_s = b_q[i*W +: W];
      end
    end
  end

  logic_slice #(.W(W)) u_slice (
    .a_s (a_s),
    .b_s (b_s),
    .op  (op_q),
    .y_s (y_s)
  );

  always_comb begin
    res_next = result_q;
    for (int i = 0; i < CHUNKS; i++) begin
      if (k == CW'(i)) begin
        res_next[i*W +: W] = y_s;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      k           <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= OP_AND;
      result_q    <= '0;
      zero_q      <= 1'b0;
      ones_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (io.in_valid) begin
            a_q        <= io.a;
            b_q        <= io.b;
            op_q       <= io.op;
            k          <= '0;
            result_q   <= '0;
            zero_q     <= 1'b0;
            ones_q     <= 1'b0;
            in_ready_q <= 1'b0;
            state      <= RUN;
          end
        end
        RUN: begin
          result_q <= res_next;
          // Flags come from res_next so they include the chunk written this edge.
          if (k == LAST) begin
            k           <= '0;
            zero_q      <= (res_next == '0);
            ones_q      <= &res_next;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            k <= k + CW'(1);
          end
        end
        DONE: begin
          if (io.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          k           <= '0;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign io.in_ready  = in_ready_q;
  assign io.out_valid = out_valid_q;
  assign io.result    = result_q;
  assign io.zero      = zero_q;
  assign io.ones      = ones_q;

endmodule

// File: tb/tb_logic_unit_seq.sv
// Bench for logic_unit_seq: op table on N=32/W=8, back-pressure and mid-run
// reset sequences, plus W=N and W=1 parameter corners.
module tb_logic_unit_seq;
  import logic_pkg::*;

  logic clk;
  logic rst_n;

  logic_unit_seq_if #(.N(32)) m_if ();
  logic_unit_seq_if #(.N(32)) w_if ();
  logic_unit_seq_if #(.N(8))  n_if ();

  logic_unit_seq #(.N(32), .W(8))  dut_main (.clk(clk), .rst_n(rst_n), .io(m_if));
  logic_unit_seq #(.N(32), .W(32)) dut_wide (.clk(clk), .rst_n(rst_n), .io(w_if));
  logic_unit_seq #(.N(8),  .W(1))  dut_bit  (.clk(clk), .rst_n(rst_n), .io(n_if));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        o;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        o;
  } exp_t;

  exp_t sbq[$];
  vec_t vecs[12];
  int   n_vec;
  int   n_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one op into the main unit at a negedge; expectation is queued at accept.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                          input logic [31:0] er, input logic ez, input logic eo, input bit push);
    int t;
    exp_t e;
    t = 0;
    while (!m_if.in_ready && t < 50) begin
      @(posedge clk);
      @(negedge clk);
      t++;
    end
    check("in_ready_before_accept", 32'(m_if.in_ready), 32'd1);
    m_if.a = a;
    m_if.b = b;
    m_if.op = op;
    m_if.in_valid = 1'b1;
    @(posedge clk);
    if (push) begin
      e.res = er;
      e.z = ez;
      e.o = eo;
      sbq.push_back(e);
    end
    @(negedge clk);
    m_if.in_valid = 1'b0;
    m_if.a = ~a;
    m_if.b = $urandom;
    m_if.op = op + 3'd3;
  endtask

  // Called at the negedge just after accept; counts edges until out_valid.
  task automatic wait_valid(input int exp_lat, input string name);
    int lat;
    lat = 0;
    while (!m_if.out_valid && lat < 50) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check(name, 32'(lat), 32'(exp_lat));
  endtask

  task automatic compare_pop(input string name);
    exp_t e;
    if (sbq.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: got output with empty scoreboard, expected a queued result", name);
    end else begin
      e = sbq.pop_front();
      check({name, "_result"}, m_if.result, e.res);
      check({name, "_zero"}, 32'(m_if.zero), 32'(e.z));
      check({name, "_ones"}, 32'(m_if.ones), 32'(e.o));
    end
  endtask

  task automatic corner_wide(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                             input logic [31:0] er, input logic ez, input logic eo);
    int lat;
    w_if.a = a;
    w_if.b = b;
    w_if.op = op;
    w_if.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    w_if.in_valid = 1'b0;
    lat = 0;
    while (!w_if.out_valid && lat < 50) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("w32_latency", 32'(lat), 32'd1);
    check("w32_result", w_if.result, er);
    check("w32_zero", 32'(w_if.zero), 32'(ez));
    check("w32_ones", 32'(w_if.ones), 32'(eo));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic corner_bit(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                            input logic [7:0] er, input logic ez, input logic eo);
    int lat;
    n_if.a = a;
    n_if.b = b;
    n_if.op = op;
    n_if.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_if.in_valid = 1'b0;
    n_if.a = ~a;
    lat = 0;
    while (!n_if.out_valid && lat < 50) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("w1_latency", 32'(lat), 32'd8);
    check("w1_result", 32'(n_if.result), 32'(er));
    check("w1_zero", 32'(n_if.zero), 32'(ez));
    check("w1_ones", 32'(n_if.ones), 32'(eo));
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    bit stable;
    bit seen;
    logic [31:0] snap;
    exp_t e2;

    n_vec = 0;
    n_err = 0;
    vecs[0]  = '{OP_AND,  32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 1'b0, 1'b0};
    vecs[1]  = '{OP_OR,   32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFFF0_FFFF, 1'b0, 1'b0};
    vecs[2]  = '{OP_XOR,  32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB, 1'b0, 1'b0};
    vecs[3]  = '{OP_ANDN, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hF000_0000, 1'b0, 1'b0};
    vecs[4]  = '{OP_ORN,  32'hF0F0_1234, 32'h0FF0_FFFF, 32'hF0FF_1234, 1'b0, 1'b0};
    vecs[5]  = '{OP_XNOR, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00FF_1234, 1'b0, 1'b0};
    vecs[6]  = '{OP_NAND, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF0F_EDCB, 1'b0, 1'b0};
    vecs[7]  = '{OP_NOR,  32'hF0F0_1234, 32'h0FF0_FFFF, 32'h000F_0000, 1'b0, 1'b0};
    vecs[8]  = '{OP_AND,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1};
    vecs[9]  = '{OP_NOR,  32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0};
    vecs[10] = '{OP_XNOR, 32'h1234_5678, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0, 1'b1};
    vecs[11] = '{OP_ANDN, 32'h0000_FF00, 32'h0000_F000, 32'h0000_0F00, 1'b0, 1'b0};

    m_if.in_valid = 1'b1; m_if.a = 32'hDEAD_BEEF; m_if.b = 32'h1; m_if.op = OP_OR; m_if.out_ready = 1'b1;
    w_if.in_valid = 1'b0; w_if.a = '0; w_if.b = '0; w_if.op = OP_AND; w_if.out_ready = 1'b1;
    n_if.in_valid = 1'b0; n_if.a = '0; n_if.b = '0; n_if.op = OP_AND; n_if.out_ready = 1'b1;
    rst_n = 1'b0;

    // Reset held with in_valid asserted: nothing may be accepted.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(m_if.in_ready), 32'd1);
    check("rst_out_valid", 32'(m_if.out_valid), 32'd0);
    check("rst_result", m_if.result, 32'd0);
    check("rst_zero", 32'(m_if.zero), 32'd0);
    check("rst_ones", 32'(m_if.ones), 32'd0);
    m_if.in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res, vecs[i].z, vecs[i].o, 1'b1);
      wait_valid(4, "latency");
      compare_pop("vec");
      @(posedge clk);
      @(negedge clk);
    end

    // Back-pressure: result held through 10 stalled cycles while a second op waits.
    m_if.out_ready = 1'b0;
    start_op(32'h0000_0001, 32'h8000_0000, OP_OR, 32'h8000_0001, 1'b0, 1'b0, 1'b1);
    wait_valid(4, "bp_latency");
    snap = m_if.result;
    m_if.a = 32'hAAAA_AAAA;
    m_if.b = 32'h5555_5555;
    m_if.op = OP_XOR;
    m_if.in_valid = 1'b1;
    stable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (m_if.result !== snap || m_if.out_valid !== 1'b1 || m_if.in_ready !== 1'b0) stable = 1'b0;
    end
    check("bp_stable", 32'(stable), 32'd1);
    compare_pop("bp_first");
    m_if.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_idle_in_ready", 32'(m_if.in_ready), 32'd1);
    check("bp_idle_out_valid", 32'(m_if.out_valid), 32'd0);
    e2.res = 32'hFFFF_FFFF;
    e2.z = 1'b0;
    e2.o = 1'b1;
    @(posedge clk);
    sbq.push_back(e2);
    @(negedge clk);
    check("bp_second_accepted", 32'(m_if.in_ready), 32'd0);
    m_if.in_valid = 1'b0;
    m_if.a = '0;
    wait_valid(4, "bp2_latency");
    compare_pop("bp_second");
    @(posedge clk);
    @(negedge clk);

    // Reset while chunk 2 is about to be processed aborts the operation.
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, OP_AND, 32'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_result", m_if.result, 32'd0);
    check("abort_out_valid", 32'(m_if.out_valid), 32'd0);
    check("abort_in_ready", 32'(m_if.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (m_if.out_valid) seen = 1'b1;
    end
    check("abort_no_valid", 32'(seen), 32'd0);
    start_op(32'h1357_9BDF, 32'hFFFF_0000, OP_XOR, 32'hECA8_9BDF, 1'b0, 1'b0, 1'b1);
    wait_valid(4, "post_abort_latency");
    compare_pop("post_abort");
    @(posedge clk);
    @(negedge clk);

    corner_wide(32'hFFFF_FFFF, 32'h0F0F_0F0F, OP_AND, 32'h0F0F_0F0F, 1'b0, 1'b0);
    corner_wide(32'h8000_0000, 32'h8000_0000, OP_XOR, 32'h0000_0000, 1'b1, 1'b0);
    corner_bit(8'hA5, 8'h5A, OP_XOR, 8'hFF, 1'b0, 1'b1);
    corner_bit(8'hA5, 8'h5A, OP_AND, 8'h00, 1'b1, 1'b0);
    corner_bit(8'hA5, 8'h0F, OP_ORN, 8'hF5, 1'b0, 1'b0);

    if (sbq.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, expected 0", sbq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
